rtc_lectura_secuenciador: RTL and testbench

//  Autonomous read sequencer for the external multiplexed-bus RTC. Each frame reads six BCD time

---
 rtl/rtc_pkg.sv | 44 ++++
 rtl/rtc_fase_cnt.sv | 28 ++
 rtl/rtc_lectura_secuenciador.sv | 199 +++++++++++++++++++
 tb/tb_rtc_lectura_secuenciador.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC read sequencer: register addresses, FSM encoding
// and small helpers for address lookup and BCD validation.
package rtc_pkg;

  localparam int N_REG = 6;

  localparam logic [7:0] DIR_SEG  = 8'h21;
  localparam logic [7:0] DIR_MIN  = 8'h22;
  localparam logic [7:0] DIR_HORA = 8'h23;
  localparam logic [7:0] DIR_DIA  = 8'h24;
  localparam logic [7:0] DIR_MES  = 8'h25;
  localparam logic [7:0] DIR_ANIO = 8'h26;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DIR_SET  = 3'd1,
    DIR_WR   = 3'd2,
    DIR_HOLD = 3'd3,
    DAT_RD   = 3'd4,
    DAT_HOLD = 3'd5,
    SIG      = 3'd6,
    COMMIT   = 3'd7
  } estado_t;

  // Bus address of the idx-th register in read order
  function automatic logic [7:0] dir_de(input logic [2:0] idx);
    logic [7:0] d;
    case (idx)
      3'd0:    d = DIR_SEG;
      3'd1:    d = DIR_MIN;
      3'd2:    d = DIR_HORA;
      3'd3:    d = DIR_DIA;
      3'd4:    d = DIR_MES;
      3'd5:    d = DIR_ANIO;
      default: d = DIR_SEG;
    endcase
    return d;
  endfunction

  function automatic logic bcd_valido(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_fase_cnt.sv
// Bus phase timer: reloads on 'carga' and raises 'fin' on the T_FASE-th cycle of a phase.
module rtc_fase_cnt #(
  parameter int T_FASE = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic carga,
  output logic fin
);

  localparam int CW = (T_FASE > 1) ? $clog2(T_FASE) : 1;

  logic [CW-1:0] cnt_reg;

  assign fin = (cnt_reg == CW'(T_FASE - 1));

  // Saturates at T_FASE-1 so an unexpected stall never wraps into a short phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (carga) begin
      cnt_reg <= '0;
    end else if (!fin) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/rtc_lectura_secuenciador.sv
// Autonomous RTC read sequencer: reads six BCD registers over the multiplexed bus each
// frame and commits them atomically to the output bank.
module rtc_lectura_secuenciador
  import rtc_pkg::*;
#(
  parameter int T_FASE     = 10,
  parameter int T_REFRESCO = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic       pausa,
  input  logic [7:0] RTC_out,
  output logic [7:0] RTC_in,
  output logic       bus_oe,
  output logic       A_D,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic       frame_ok,
  output logic       ocupado,
  output logic       bcd_err
);

  localparam int TW = (T_REFRESCO > 1) ? $clog2(T_REFRESCO) : 1;

  estado_t         estado_reg, estado_next;
  logic [2:0]      idx_reg, idx_next;
  logic [TW-1:0]   timer_reg;
  logic            timer_fin;
  logic            arranque;
  logic            fin;
  logic            carga;

  logic            cs_reg, rd_reg, wr_reg, a_d_reg, oe_reg;
  logic            cs_next, rd_next, wr_next, a_d_next, oe_next;
  logic [7:0]      dir_reg, dir_next;
  logic            frame_ok_reg, ocupado_reg, bcd_err_reg;

  logic [7:0]      sombra_reg [N_REG];
  logic [7:0]      valor_reg  [N_REG];
  logic [N_REG-1:0] nib_ok;

  assign timer_fin = (timer_reg == TW'(T_REFRESCO - 1));
  assign carga     = (estado_next != estado_reg);

  rtc_fase_cnt #(
    .T_FASE (T_FASE)
  ) u_fase (
    .clk   (clk),
    .reset (reset),
    .carga (carga),
    .fin   (fin)
  );

  // Next state, then the strobe pattern for the state being entered so the
  // pins are registered and line up exactly with the state register.
  always_comb begin
    estado_next = estado_reg;
    idx_next    = idx_reg;
    arranque    = 1'b0;
    cs_next     = 1'b1;
    rd_next     = 1'b1;
    wr_next     = 1'b1;
    a_d_next    = 1'b1;
    oe_next     = 1'b0;
    dir_next    = 8'h00;

    case (estado_reg)
      IDLE: begin
        if ((inicio || timer_fin) && !pausa) begin
          arranque    = 1'b1;
          idx_next    = 3'd0;
          estado_next = DIR_SET;
        end
      end
      DIR_SET:  if (fin) estado_next = DIR_WR;
      DIR_WR:   if (fin) estado_next = DIR_HOLD;
      DIR_HOLD: if (fin) estado_next = DAT_RD;
      DAT_RD:   if (fin) estado_next = DAT_HOLD;
      DAT_HOLD: if (fin) estado_next = SIG;
      SIG: begin
        if (idx_reg == 3'(N_REG - 1)) begin
          estado_next = COMMIT;
        end else begin
          idx_next    = idx_reg + 3'd1;
          estado_next = DIR_SET;
        end
      end
      COMMIT:   estado_next = IDLE;
      default:  estado_next = IDLE;
    endcase

    case (estado_next)
      DIR_SET: begin
        a_d_next = 1'b0;
        cs_next  = 1'b0;
        oe_next  = 1'b1;
        dir_next = dir_de(idx_next);
      end
      DIR_WR: begin
        a_d_next = 1'b0;
        cs_next  = 1'b0;
        wr_next  = 1'b0;
        oe_next  = 1'b1;
        dir_next = dir_de(idx_next);
      end
      DIR_HOLD: begin
        a_d_next = 1'b0;
        oe_next  = 1'b1;
        dir_next = dir_de(idx_next);
      end
      DAT_RD: begin
        cs_next = 1'b0;
        rd_next = 1'b0;
      end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REG; gi++) begin : g_bcd
      assign nib_ok[gi] = bcd_valido(sombra_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_reg   <= IDLE;
      idx_reg      <= 3'd0;
      timer_reg    <= '0;
      cs_reg       <= 1'b1;
      rd_reg       <= 1'b1;
      wr_reg       <= 1'b1;
      a_d_reg      <= 1'b1;
      oe_reg       <= 1'b0;
      dir_reg      <= 8'h00;
      frame_ok_reg <= 1'b0;
      ocupado_reg  <= 1'b0;
      bcd_err_reg  <= 1'b0;
      for (int i = 0; i < N_REG; i++) begin
        valor_reg[i] <= 8'h00;
      end
    end else begin
      estado_reg   <= estado_next;
      idx_reg      <= idx_next;
      timer_reg    <= (arranque || timer_fin) ? '0 : timer_reg + 1'b1;
      cs_reg       <= cs_next;
      rd_reg       <= rd_next;
      wr_reg       <= wr_next;
      a_d_reg      <= a_d_next;
      oe_reg       <= oe_next;
      dir_reg      <= dir_next;
      frame_ok_reg <= (estado_next == COMMIT);
      ocupado_reg  <= (estado_next != IDLE);
      if (arranque) begin
        bcd_err_reg <= 1'b0;
      end else if (estado_next == COMMIT) begin
        bcd_err_reg <= ~(&nib_ok);
      end
      if (estado_next == COMMIT) begin
        for (int i = 0; i < N_REG; i++) begin
          valor_reg[i] <= sombra_reg[i];
        end
      end
    end
  end

  // Shadow bank: sampled on the last cycle of the read strobe
  always_ff @(posedge clk) begin
    if (estado_reg == DAT_RD && fin) begin
      sombra_reg[idx_reg] <= RTC_out;
    end
  end

  assign CS       = cs_reg;
  assign RD       = rd_reg;
  assign WR       = wr_reg;
  assign A_D      = a_d_reg;
  assign bus_oe   = oe_reg;
  assign RTC_in   = dir_reg;
  assign frame_ok = frame_ok_reg;
  assign ocupado  = ocupado_reg;
  assign bcd_err  = bcd_err_reg;
  assign seg      = valor_reg[0];
  assign min      = valor_reg[1];
  assign hora     = valor_reg[2];
  assign dia      = valor_reg[3];
  assign mes      = valor_reg[4];
  assign anio     = valor_reg[5];

endmodule

// File: tb/tb_rtc_lectura_secuenciador.sv
// Directed bench for rtc_lectura_secuenciador with a simple multiplexed-bus RTC model.
module tb_rtc_lectura_secuenciador;

  localparam int T_FASE     = 10;
  localparam int T_REFRESCO = 1000;
  localparam int FRAME_LEN  = 6 * (5 * T_FASE + 1) + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       inicio = 1'b0;
  logic       pausa = 1'b0;
  logic [7:0] RTC_out;
  logic [7:0] RTC_in;
  logic       bus_oe, A_D, CS, RD, WR;
  logic [7:0] seg, min, hora, dia, mes, anio;
  logic       frame_ok, ocupado, bcd_err;

  logic [7:0] modelo [6];
  logic [7:0] dir_lat = 8'h00;
  logic [2:0] m_idx;
  logic [7:0] wr_log [1024];
  int         wr_cnt = 0;

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;
  logic fo_prev = 1'b0;

  rtc_lectura_secuenciador #(
    .T_FASE     (T_FASE),
    .T_REFRESCO (T_REFRESCO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .inicio   (inicio),
    .pausa    (pausa),
    .RTC_out  (RTC_out),
    .RTC_in   (RTC_in),
    .bus_oe   (bus_oe),
    .A_D      (A_D),
    .CS       (CS),
    .RD       (RD),
    .WR       (WR),
    .seg      (seg),
    .min      (min),
    .hora     (hora),
    .dia      (dia),
    .mes      (mes),
    .anio     (anio),
    .frame_ok (frame_ok),
    .ocupado  (ocupado),
    .bcd_err  (bcd_err)
  );

  always #5 clk = ~clk;

  // RTC model: address latched on WR rising, register driven while RD is low
  always @(posedge WR) begin
    dir_lat <= RTC_in;
    wr_log[wr_cnt % 1024] <= RTC_in;
    wr_cnt <= wr_cnt + 1;
  end

  assign m_idx = 3'(dir_lat - 8'h21);
  always_comb begin
    RTC_out = 8'hFF;
    if (!RD && dir_lat >= 8'h21 && dir_lat <= 8'h26) RTC_out = modelo[m_idx];
  end

  always @(negedge clk) begin
    if (reset) begin
      assert (!(!RD && !WR)) else begin
        viol++;
        $error("FAIL mon_rd_wr observed RD=%0b WR=%0b required not both 0", RD, WR);
      end
      assert (!(!RD && bus_oe)) else begin
        viol++;
        $error("FAIL mon_oe_rd observed bus_oe=%0b with RD=0 required 0", bus_oe);
      end
      assert (!(frame_ok && fo_prev)) else begin
        viol++;
        $error("FAIL mon_frame_ok_width observed 2-cycle pulse required 1 cycle");
      end
    end
    fo_prev = frame_ok;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(output int n);
    @(negedge clk);
    inicio = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
    n = 1;
    while (!frame_ok && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int base;
    int torn;
    int cs_act;
    int busy;
    int p;
    logic prev;

    modelo = '{8'h45, 8'h59, 8'h23, 8'h31, 8'h12, 8'h16};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_CS", CS, 1);
    check("rst_RD", RD, 1);
    check("rst_WR", WR, 1);
    check("rst_A_D", A_D, 1);
    check("rst_bus_oe", bus_oe, 0);
    check("rst_RTC_in", RTC_in, 8'h00);
    check("rst_seg", seg, 8'h00);
    check("rst_anio", anio, 8'h00);
    check("rst_frame_ok", frame_ok, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_bcd_err", bcd_err, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);

    // 1: basic frame
    base = wr_cnt;
    run_frame(n);
    $display("[TB] t1 frame latency=%0d", n);
    check("t1_latency", n, FRAME_LEN);
    check("t1_ocupado", ocupado, 1);
    check("t1_seg", seg, 8'h45);
    check("t1_min", min, 8'h59);
    check("t1_hora", hora, 8'h23);
    check("t1_dia", dia, 8'h31);
    check("t1_mes", mes, 8'h12);
    check("t1_anio", anio, 8'h16);
    check("t1_bcd_err", bcd_err, 0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t1_wr_addr%0d", i), wr_log[(base + i) % 1024], 8'h21 + i);
    end
    @(posedge clk);
    #1;
    check("t1_frame_ok_drop", frame_ok, 0);
    check("t1_ocupado_drop", ocupado, 0);

    // 2: seg changes mid-frame after it has been read
    modelo[0] = 8'h59;
    @(negedge clk);
    inicio = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
    n = 1;
    torn = 0;
    while (!frame_ok && n < 2000) begin
      if (n == 60) modelo[0] = 8'h00;
      if (seg !== 8'h45 || min !== 8'h59 || hora !== 8'h23) torn++;
      @(posedge clk);
      #1;
      n++;
    end
    $display("[TB] t2 frame latency=%0d torn=%0d seg=%0h", n, torn, seg);
    check("t2_latency", n, FRAME_LEN);
    check("t2_no_early_change", torn, 0);
    check("t2_seg", seg, 8'h59);
    check("t2_min", min, 8'h59);

    // 3a: paused -- no bus activity through an inicio and a timer expiry
    @(negedge clk);
    pausa = 1'b1;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    cs_act = 0;
    busy = 0;
    repeat (1100) begin
      @(negedge clk);
      if (!CS) cs_act++;
      if (ocupado) busy++;
    end
    $display("[TB] t3 paused cs_low=%0d busy=%0d", cs_act, busy);
    check("t3_cs_idle", cs_act, 0);
    check("t3_not_busy", busy, 0);

    // 3b: pausa rising mid-frame does not abort it
    @(negedge clk);
    pausa = 1'b0;
    inicio = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
    check("t3_start", ocupado, 1);
    n = 1;
    while (!frame_ok && n < 2000) begin
      if (n == 100) pausa = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    $display("[TB] t3 paused-mid frame latency=%0d", n);
    check("t3_pausa_latency", n, FRAME_LEN);
    check("t3_seg", seg, 8'h00);
    pausa = 1'b0;
    repeat (3) @(posedge clk);

    // 4: reset during a read strobe
    modelo = '{8'h12, 8'h34, 8'h09, 8'h01, 8'h02, 8'h24};
    @(negedge clk);
    inicio = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
    n = 1;
    while (n < 138) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t4_rd_active", RD, 0);
    reset = 1'b0;
    #1;
    $display("[TB] t4 async reset CS=%0b RD=%0b WR=%0b oe=%0b", CS, RD, WR, bus_oe);
    check("t4_CS", CS, 1);
    check("t4_RD", RD, 1);
    check("t4_WR", WR, 1);
    check("t4_bus_oe", bus_oe, 0);
    check("t4_ocupado", ocupado, 0);
    check("t4_seg", seg, 8'h00);
    check("t4_min", min, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    run_frame(n);
    $display("[TB] t4 fresh frame latency=%0d", n);
    check("t4_latency", n, FRAME_LEN);
    check("t4_seg_after", seg, 8'h12);
    check("t4_min_after", min, 8'h34);
    check("t4_hora_after", hora, 8'h09);
    check("t4_anio_after", anio, 8'h24);

    // 5: invalid BCD flagged, then cleared by a clean frame
    modelo[2] = 8'h3A;
    run_frame(n);
    $display("[TB] t5 bad bcd frame hora=%0h bcd_err=%0b", hora, bcd_err);
    check("t5_bcd_err_set", bcd_err, 1);
    check("t5_hora", hora, 8'h3A);
    modelo[2] = 8'h23;
    run_frame(n);
    $display("[TB] t5 clean frame hora=%0h bcd_err=%0b", hora, bcd_err);
    check("t5_bcd_err_clr", bcd_err, 0);
    check("t5_hora_ok", hora, 8'h23);

    // 6: automatic frames every T_REFRESCO cycles with inicio idle
    prev = ocupado;
    p = 0;
    while (p < 2500) begin
      @(posedge clk);
      #1;
      p++;
      if (ocupado && !prev) break;
      prev = ocupado;
    end
    check("t6_auto_start", ocupado, 1);
    prev = ocupado;
    p = 0;
    while (p < 2500) begin
      @(posedge clk);
      #1;
      p++;
      if (ocupado && !prev) break;
      prev = ocupado;
    end
    $display("[TB] t6 auto frame period=%0d", p);
    check("t6_period", p, T_REFRESCO);

    check("mon_violations", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
